// File: rtl/arb_pkg.sv
// Shared encodings for the memory-port arbiter: FSM states and requester IDs.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef logic owner_t;

    localparam owner_t OWN_CPU = 1'b0;
    localparam owner_t OWN_DMA = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// Two-requester round-robin select: a tie goes to whoever was not served last.
module rr_pick2
    import arb_pkg::*;
(
    input  logic [1:0] req,        // indexed by owner ID
    input  owner_t     last_owner,
    output logic       valid,
    output owner_t     winner
);

    always_comb begin
        // NOTE: every output gets a default first so no path through the block can infer a latch.
        valid  = |req;
        winner = OWN_CPU;
        if (req == 2'b11) begin
            winner = ~last_owner;
        end else if (req[OWN_DMA]) begin
            winner = OWN_DMA;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the CPU control unit and the DMA engine.
// Each granted access is latched, held on the memory for ACCESS_CYCLES, then completed.
module mem_port_arbiter
    import arb_pkg::*;
#(
    parameter int AW            = 8,
    parameter int DW            = 8,
    parameter int ACCESS_CYCLES = 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_done,
    output logic [DW-1:0] cpu_rdata,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic          dma_gnt,
    output logic          dma_done,
    output logic [DW-1:0] dma_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_read,
    output logic          mem_write,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    generate
        if (ACCESS_CYCLES < 1 || ACCESS_CYCLES > 15) begin : g_bad_cfg
            $error("mem_port_arbiter: ACCESS_CYCLES must lie in 1..15");
        end
    endgenerate

    localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

    state_t        state, state_next;
    logic [3:0]    cnt, cnt_next;
    owner_t        owner, last_owner;
    logic          we_l;
    logic [AW-1:0] addr_l;
    logic [DW-1:0] wdata_l;
    logic [DW-1:0] cpu_rdata_q, dma_rdata_q;
    logic          pick_valid;
    owner_t        pick_winner;
    logic          grant, last_beat;

    rr_pick2 u_pick (
        .req        ({dma_req, cpu_req}),
        .last_owner (last_owner),
        .valid      (pick_valid),
        .winner     (pick_winner)
    );

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        grant      = 1'b0;
        last_beat  = 1'b0;
        unique case (state)
            IDLE: begin
                if (pick_valid) begin
                    grant      = 1'b1;
                    cnt_next   = CNT_LOAD;
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt == 4'd0) begin
                    last_beat  = 1'b1;
                    state_next = RESP;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: the async reset also clears both read-data holding registers, so no stale data survives it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            owner       <= OWN_CPU;
            last_owner  <= OWN_DMA;
            we_l        <= 1'b0;
            addr_l      <= '0;
            wdata_l     <= '0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else begin
            // NOTE: non-blocking throughout so every register samples the pre-edge values.
            state <= state_next;
            cnt   <= cnt_next;
            if (grant) begin
                owner      <= pick_winner;
                last_owner <= pick_winner;
                we_l       <= (pick_winner == OWN_DMA) ? dma_we    : cpu_we;
                addr_l     <= (pick_winner == OWN_DMA) ? dma_addr  : cpu_addr;
                wdata_l    <= (pick_winner == OWN_DMA) ? dma_wdata : cpu_wdata;
            end
            // Writes leave the owner's read data untouched.
            if (last_beat && !we_l) begin
                if (owner == OWN_CPU) cpu_rdata_q <= mem_rdata;
                else                  dma_rdata_q <= mem_rdata;
            end
        end
    end

    assign busy      = (state != IDLE);
    assign cpu_gnt   = busy && (owner == OWN_CPU);
    assign dma_gnt   = busy && (owner == OWN_DMA);
    assign cpu_done  = (state == RESP) && (owner == OWN_CPU);
    assign dma_done  = (state == RESP) && (owner == OWN_DMA);
    assign mem_read  = (state == ACCESS) && !we_l;
    assign mem_write = (state == ACCESS) && we_l;
    assign mem_addr  = addr_l;
    assign mem_wdata = wdata_l;
    assign cpu_rdata = cpu_rdata_q;
    assign dma_rdata = dma_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus a randomized run against a
// transaction-level model (grant edge, fixed access length, round-robin on tie).
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    localparam int AW = 8;
    localparam int DW = 8;
    localparam int AC = 3;
    localparam int P  = AC + 2;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          cpu_req = 1'b0, cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          dma_req = 1'b0, dma_we = 1'b0;
    logic [AW-1:0] dma_addr = '0;
    logic [DW-1:0] dma_wdata = '0;
    logic          cpu_gnt, cpu_done, dma_gnt, dma_done;
    logic [DW-1:0] cpu_rdata, dma_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          mem_read, mem_write, busy;

    logic [7:0]    mem [0:255];
    logic          pre_we = 1'b0;
    logic [7:0]    pre_a = '0, pre_d = '0;

    int total = 0;
    int bad   = 0;

    logic [22:0] obs;
    logic [15:0] rd_obs;

    always #5 clock = ~clock;

    mem_port_arbiter #(.AW(AW), .DW(DW), .ACCESS_CYCLES(AC)) dut (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_done(dma_done), .dma_rdata(dma_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
        .mem_write(mem_write), .mem_rdata(mem_rdata), .busy(busy)
    );

    // Memory model: combinational read, write on the clock edge while strobed.
    assign mem_rdata = mem[mem_addr];
    always @(posedge clock) begin
        if (mem_write)   mem[mem_addr] <= mem_wdata;
        else if (pre_we) mem[pre_a]    <= pre_d;
    end

    assign obs    = {busy, cpu_gnt, dma_gnt, cpu_done, dma_done, mem_read, mem_write, mem_addr, mem_wdata};
    assign rd_obs = {cpu_rdata, dma_rdata};

    // Expected control/address bundle. ph: 0 idle, 1 access, 2 response.
    function automatic logic [22:0] mk(int ph, logic own, logic we, logic [7:0] a, logic [7:0] d);
        logic act, acc, rsp;
        acc = (ph == 1);
        rsp = (ph == 2);
        act = acc | rsp;
        return {act, act && !own, act && own, rsp && !own, rsp && own, acc && !we, acc && we, a, d};
    endfunction

    task automatic mem_load(input logic [7:0] a, input logic [7:0] d);
        pre_we = 1'b1; pre_a = a; pre_d = d;
        @(negedge clock);
        pre_we = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clock);
        total++;
        if (obs !== 23'd0) begin bad++; $display("FAIL reset_ctl got=%h want=%h", obs, 23'd0); end
        total++;
        if (rd_obs !== 16'd0) begin bad++; $display("FAIL reset_rdata got=%h want=%h", rd_obs, 16'd0); end
        cpu_req = 1'b1; dma_req = 1'b1;
        @(negedge clock);
        total++;
        if (obs !== 23'd0) begin bad++; $display("FAIL reset_hold got=%h want=%h", obs, 23'd0); end
        cpu_req = 1'b0; dma_req = 1'b0;
        reset = 1'b0;
        @(negedge clock);
        total++;
        if (obs !== 23'd0) begin bad++; $display("FAIL reset_noreq got=%h want=%h", obs, 23'd0); end
    endtask

    task automatic test_single_access(input string name, input logic own, input logic we,
                                      input logic [7:0] a, input logic [7:0] d, input logic [15:0] exp_rd);
        int ph;
        do_reset();
        if (own) begin dma_req = 1'b1; dma_we = we; dma_addr = a; dma_wdata = d; end
        else     begin cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d; end
        for (int k = 0; k <= AC + 1; k++) begin
            @(negedge clock);
            ph = (k < AC) ? 1 : (k == AC) ? 2 : 0;
            total++;
            if (obs !== mk(ph, own, we, a, d)) begin
                bad++; $display("FAIL %s_ctl k=%0d got=%h want=%h", name, k, obs, mk(ph, own, we, a, d));
            end
            total++;
            if (rd_obs !== ((k >= AC) ? exp_rd : 16'd0)) begin
                bad++; $display("FAIL %s_rdata k=%0d got=%h want=%h", name, k, rd_obs, (k >= AC) ? exp_rd : 16'd0);
            end
            if (k == AC) begin cpu_req = 1'b0; dma_req = 1'b0; end
        end
    endtask

    task automatic test_tie_from_reset();
        int ph, k2;
        logic [22:0] want;
        mem_load(8'h20, 8'h00);
        do_reset();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h20; cpu_wdata = 8'h3C;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 8'h20; dma_wdata = 8'h99;
        for (int k = 0; k <= 2 * AC + 3; k++) begin
            @(negedge clock);
            if (k < P) begin
                ph = (k < AC) ? 1 : (k == AC) ? 2 : 0;
                want = mk(ph, 1'b0, 1'b1, 8'h20, 8'h3C);
            end else begin
                k2 = k - P;
                ph = (k2 < AC) ? 1 : (k2 == AC) ? 2 : 0;
                want = mk(ph, 1'b1, 1'b0, 8'h20, 8'h99);
            end
            total++;
            if (obs !== want) begin bad++; $display("FAIL tie_ctl k=%0d got=%h want=%h", k, obs, want); end
            total++;
            if (rd_obs !== ((k >= P + AC) ? 16'h003C : 16'h0000)) begin
                bad++; $display("FAIL tie_rdata k=%0d got=%h want=%h", k, rd_obs, (k >= P + AC) ? 16'h003C : 16'h0000);
            end
            if (k == AC)         cpu_req = 1'b0;
            if (k == P + AC)     dma_req = 1'b0;
        end
    endtask

    task automatic test_contention();
        int j, r, ph;
        logic own;
        logic [15:0] want_rd;
        mem_load(8'h30, 8'h5A);
        mem_load(8'h31, 8'hC3);
        do_reset();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h30;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 8'h31;
        for (int k = 0; k < 6 * P; k++) begin
            @(negedge clock);
            j   = k / P;
            r   = k % P;
            own = j[0];
            ph  = (r < AC) ? 1 : (r == AC) ? 2 : 0;
            total++;
            if (obs !== mk(ph, own, 1'b0, own ? 8'h31 : 8'h30, 8'h00)) begin
                bad++; $display("FAIL contention_ctl k=%0d got=%h want=%h", k, obs, mk(ph, own, 1'b0, own ? 8'h31 : 8'h30, 8'h00));
            end
            want_rd[15:8] = (j > 0 || r >= AC) ? 8'h5A : 8'h00;
            want_rd[7:0]  = (j > 1 || (j == 1 && r >= AC)) ? 8'hC3 : 8'h00;
            total++;
            if (rd_obs !== want_rd) begin bad++; $display("FAIL contention_rdata k=%0d got=%h want=%h", k, rd_obs, want_rd); end
            if (j == 5 && r == AC) begin cpu_req = 1'b0; dma_req = 1'b0; end
        end
    endtask

    task automatic test_input_change();
        int ph;
        mem_load(8'h40, 8'h11);
        mem_load(8'h41, 8'h22);
        do_reset();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h40; cpu_wdata = 8'h00;
        for (int k = 0; k <= AC + 1; k++) begin
            @(negedge clock);
            ph = (k < AC) ? 1 : (k == AC) ? 2 : 0;
            total++;
            if (obs !== mk(ph, 1'b0, 1'b0, 8'h40, 8'h00)) begin
                bad++; $display("FAIL input_change_ctl k=%0d got=%h want=%h", k, obs, mk(ph, 1'b0, 1'b0, 8'h40, 8'h00));
            end
            if (k == 0) begin cpu_addr = 8'h41; cpu_we = 1'b1; cpu_wdata = 8'hFF; end
            if (k == AC) begin
                total++;
                if (rd_obs !== 16'h1100) begin bad++; $display("FAIL input_change_rdata got=%h want=%h", rd_obs, 16'h1100); end
                cpu_req = 1'b0;
            end
        end
    endtask

    task automatic test_drop_before_grant();
        int ph;
        do_reset();
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 8'h07; dma_wdata = 8'h42;
        for (int k = 0; k <= AC + 3; k++) begin
            @(negedge clock);
            ph = (k < AC) ? 1 : (k == AC) ? 2 : 0;
            total++;
            if (obs !== mk(ph, 1'b1, 1'b1, 8'h07, 8'h42)) begin
                bad++; $display("FAIL drop_ctl k=%0d got=%h want=%h", k, obs, mk(ph, 1'b1, 1'b1, 8'h07, 8'h42));
            end
            if (k == 0)      begin cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10; end
            if (k == AC - 1) cpu_req = 1'b0;
            if (k == AC)     dma_req = 1'b0;
        end
    endtask

    task automatic test_reset_mid_access();
        int ph;
        mem_load(8'h10, 8'hA5);
        do_reset();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h50; cpu_wdata = 8'h77;
        for (int k = 0; k < 2; k++) begin
            @(negedge clock);
            total++;
            if (obs !== mk(1, 1'b0, 1'b1, 8'h50, 8'h77)) begin
                bad++; $display("FAIL midreset_pre k=%0d got=%h want=%h", k, obs, mk(1, 1'b0, 1'b1, 8'h50, 8'h77));
            end
        end
        #2 reset = 1'b1;
        #1;
        total++;
        if (obs !== 23'd0) begin bad++; $display("FAIL midreset_async got=%h want=%h", obs, 23'd0); end
        cpu_req = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clock);
            total++;
            if (obs !== 23'd0) begin bad++; $display("FAIL midreset_nodone k=%0d got=%h want=%h", k, obs, 23'd0); end
        end
        reset = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10; cpu_wdata = 8'h00;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 8'h05; dma_wdata = 8'h00;
        for (int k = 0; k <= AC + 1; k++) begin
            @(negedge clock);
            ph = (k < AC) ? 1 : (k == AC) ? 2 : 0;
            total++;
            if (obs !== mk(ph, 1'b0, 1'b0, 8'h10, 8'h00)) begin
                bad++; $display("FAIL midreset_tie k=%0d got=%h want=%h", k, obs, mk(ph, 1'b0, 1'b0, 8'h10, 8'h00));
            end
            if (k == 0) dma_req = 1'b0;
            if (k == AC) begin
                total++;
                if (rd_obs !== 16'hA500) begin bad++; $display("FAIL midreset_rdata got=%h want=%h", rd_obs, 16'hA500); end
                cpu_req = 1'b0;
            end
        end
    endtask

    // Transaction-level model: a grant may only happen on an edge at least
    // AC+2 edges after the previous one; the access then spans AC cycles,
    // followed by one response cycle.
    task automatic test_random();
        logic [7:0] ref_mem [16];
        logic       rq [2];
        logic       rwe [2];
        logic [7:0] raddr [2];
        logic [7:0] rwd [2];
        logic [7:0] exp_rd [2];
        int         e, g, next_free, k, ph;
        logic       have, own, twe, last_own, w;
        logic [7:0] taddr, twd;

        for (int a = 0; a < 16; a++) begin
            ref_mem[a] = 8'($urandom);
            mem_load(8'(a), ref_mem[a]);
        end
        do_reset();
        for (int r = 0; r < 2; r++) begin
            rq[r] = 1'b0; rwe[r] = 1'b0; raddr[r] = '0; rwd[r] = '0; exp_rd[r] = '0;
        end
        e = 0; g = 0; next_free = 1; have = 1'b0; own = 1'b0; twe = 1'b0;
        last_own = 1'b1; taddr = '0; twd = '0;

        repeat (3000) begin
            if (e + 1 >= next_free && (rq[0] || rq[1])) begin
                if (rq[0] && rq[1]) w = ~last_own;
                else                w = rq[1];
                have = 1'b1; g = e + 1; own = w;
                twe = rwe[w]; taddr = raddr[w]; twd = rwd[w];
                last_own = w; next_free = g + AC + 2;
            end
            @(negedge clock);
            e++;
            k  = have ? (e - g) : (AC + 1);
            ph = (k < AC) ? 1 : (k == AC) ? 2 : 0;
            if (ph == 2) begin
                if (twe) ref_mem[taddr[3:0]] = twd;
                else     exp_rd[own] = ref_mem[taddr[3:0]];
            end
            total++;
            if (obs !== mk(ph, own, twe, taddr, twd)) begin
                bad++; $display("FAIL random_ctl e=%0d got=%h want=%h", e, obs, mk(ph, own, twe, taddr, twd));
            end
            total++;
            if (rd_obs !== {exp_rd[0], exp_rd[1]}) begin
                bad++; $display("FAIL random_rdata e=%0d got=%h want=%h", e, rd_obs, {exp_rd[0], exp_rd[1]});
            end
            for (int r = 0; r < 2; r++) begin
                if (have && own == r && ph == 2) begin
                    if ($urandom_range(3) == 0) begin
                        rq[r] = 1'b1; rwe[r] = 1'($urandom); raddr[r] = {4'h0, 4'($urandom)}; rwd[r] = 8'($urandom);
                    end else begin
                        rq[r] = 1'b0;
                    end
                end else if (have && own == r && ph == 1) begin
                    if ($urandom_range(2) == 0) begin
                        rwe[r] = 1'($urandom); raddr[r] = 8'($urandom); rwd[r] = 8'($urandom);
                    end
                end else if (!rq[r]) begin
                    if ($urandom_range(2) == 0) begin
                        rq[r] = 1'b1; rwe[r] = 1'($urandom); raddr[r] = {4'h0, 4'($urandom)}; rwd[r] = 8'($urandom);
                    end
                end else if ($urandom_range(7) == 0) begin
                    rq[r] = 1'b0;
                end
            end
            cpu_req = rq[0]; cpu_we = rwe[0]; cpu_addr = raddr[0]; cpu_wdata = rwd[0];
            dma_req = rq[1]; dma_we = rwe[1]; dma_addr = raddr[1]; dma_wdata = rwd[1];
        end
        cpu_req = 1'b0; dma_req = 1'b0;
    endtask

    initial begin
        test_reset();
        mem_load(8'h10, 8'hA5);
        test_single_access("cpu_read", 1'b0, 1'b0, 8'h10, 8'h00, 16'hA500);
        mem_load(8'h05, 8'h6E);
        test_single_access("dma_read", 1'b1, 1'b0, 8'h05, 8'h00, 16'h006E);
        test_single_access("dma_write", 1'b1, 1'b1, 8'h06, 8'h9D, 16'h0000);
        test_tie_from_reset();
        test_contention();
        test_input_change();
        test_drop_before_grant();
        test_reset_mid_access();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port main memory between two requesters: the CPU control unit (instruction fetch, operand read, store) and a DMA/IO engine.
- Arbitration is round-robin on tie. Each granted access is latched and driven onto the memory for a fixed, parameterised number of cycles, then completed with a one-cycle done pulse and registered read data.
- Sits between the control unit / DMA engine and the memory model. Every memory control line comes from this block's registers.

Parameters:
- AW, 8, address width in bits.
- DW, 8, data width in bits.
- ACCESS_CYCLES, 1, cycles memory strobes are held per access; legal range 1..15.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- cpu_req  input  1  CPU access request; held until cpu_done.
- cpu_we  input  1  1 = write, 0 = read; sampled at grant.
- cpu_addr  input  AW  CPU address; sampled at grant.
- cpu_wdata  input  DW  CPU write data; sampled at grant.
- cpu_gnt  output  1  high while the CPU access is in progress (ACCESS and RESP).
- cpu_done  output  1  one-cycle completion pulse.
- cpu_rdata  output  DW  read data; valid when cpu_done=1 and held until the next CPU read completes.
- dma_req, dma_we, dma_addr, dma_wdata  input  1/1/AW/DW  same rules as the cpu_* inputs.
- dma_gnt, dma_done, dma_rdata  output  1/1/DW  same rules as the cpu_* outputs.
- mem_addr  output  AW  latched address.
- mem_wdata  output  DW  latched write data.
- mem_read  output  1  read strobe.
- mem_write  output  1  write strobe.
- mem_rdata  input  DW  combinational memory read data.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async):
  - state=IDLE; all outputs 0; rdata registers 0; access counter 0.
  - last_owner=DMA, so the CPU wins the first tie.
  - Reset mid-access drops mem_read/mem_write immediately. The access is abandoned and no done pulse is issued.
- States: IDLE, ACCESS, RESP. All outputs are decoded from registered state/latches; there is no combinational path from any *_req to any output.
- IDLE:
  - No request: stay in IDLE.
  - Only one req high: grant that requester.
  - Both high: grant the requester that is not last_owner.
  - On grant:
    - latch we/addr/wdata and owner;
    - set last_owner=owner;
    - counter=ACCESS_CYCLES-1;
    - next state ACCESS.
- ACCESS:
  - mem_addr/mem_wdata = latched values.
  - mem_read = !we_l; mem_write = we_l.
  - Counter decrements each cycle.
  - When the counter is 0: capture mem_rdata into the owner's rdata register (reads only; write leaves rdata unchanged); next state RESP.
- RESP:
  - Strobes low; owner's *_done=1 for this cycle; next state IDLE.
- Latency:
  - req seen high at edge k.
  - Strobes asserted during cycles k+1 .. k+ACCESS_CYCLES.
  - done in cycle k+ACCESS_CYCLES+1.
  - Minimum spacing between grants is ACCESS_CYCLES+2 cycles.
- Handshake rules:
  - A requester holds req and its inputs stable until done.
  - A requester deasserts req on the edge ending the done cycle, unless it wants a back-to-back access.
  - req still high in the IDLE cycle after done counts as a new request and is arbitrated normally, so round-robin alternates under contention.
  - Input changes after grant are ignored.
  - req dropped before grant is never served.
  - *_gnt is high for exactly one requester, or neither.
- mem_wdata holds its last value outside ACCESS; only the strobes qualify it.
- ACCESS_CYCLES outside 1..15 is a configuration error, flagged at elaboration.

Decomposition:
- Shared package arb_pkg:
  - state encoding constants (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2);
  - owner IDs (OWN_CPU=1'b0, OWN_DMA=1'b1).
- One sub-module, rr_pick2: combinational two-requester round-robin select. Inputs req[1:0] and last_owner; outputs valid and winner.

Test Plan:
- CPU read only: mem[0x10]=0xA5, ACCESS_CYCLES=1, cpu_req at edge 1 → mem_read high cycle 2 with mem_addr=0x10; cpu_done cycle 3 with cpu_rdata=0xA5; dma outputs stay 0.
- Simultaneous req from reset: CPU write 0x3C to 0x20 and DMA read 0x20, both held → CPU served first (mem_write, data 0x3C); DMA granted in the next IDLE and reads 0x3C.
- Continuous contention: both req held for 6 accesses → grants alternate CPU, DMA, CPU, DMA, CPU, DMA; done pulses are 3 cycles apart (ACCESS_CYCLES=1).
- ACCESS_CYCLES=3, DMA read of 0x05 → mem_read high for exactly 3 cycles; dma_done on the 4th cycle after grant; mem_addr stable at 0x05 throughout.
- Reset asserted in the 2nd ACCESS cycle of a CPU write (ACCESS_CYCLES=3) → mem_write falls with reset (no clock edge needed); no cpu_done; after release, first tie goes to the CPU.
- Inputs changed after grant: cpu_addr switched 0x40→0x41 one cycle after grant → mem_addr stays 0x40; a CPU req dropped before a grant produces no access.
